// File: rtl/tidc_txn_watchdog.sv
// Multi-port transaction watchdog: per-port timestamp FIFOs, latency, timeout and error accounting.
// Optional per-port max-latency tracking is built only when TIDC_WDOG_LAT_STATS_EN is defined.
module tidc_txn_watchdog #(
    parameter int NUM_PORTS = 2,
    parameter int MAX_OUT   = 4,
    parameter int TS_W      = 16,
    parameter int TIMEOUT   = 1000
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         enable,
    input  logic                                         clear,
    input  logic [NUM_PORTS-1:0]                         req_valid,
    input  logic [NUM_PORTS-1:0]                         req_ready,
    input  logic [NUM_PORTS-1:0]                         rsp_valid,
    input  logic [NUM_PORTS-1:0]                         rsp_error,
    output logic [31:0]                                  total_cycles,
    output logic [31:0]                                  success_count,
    output logic [31:0]                                  error_count,
    output logic                                         timeout_detected,
    output logic [NUM_PORTS-1:0]                         timeout_port,
    output logic [NUM_PORTS*($clog2(MAX_OUT)+1)-1:0]     outstanding,
    output logic [NUM_PORTS*TS_W-1:0]                    max_latency
);

    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [TS_W-1:0]  TIMEOUT_TS = TS_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(MAX_OUT);

    logic [TS_W-1:0]      now_q;
    logic [31:0]          total_q;
    logic [31:0]          success_q;
    logic [31:0]          error_q;
    logic                 timeout_det_q;

    logic [NUM_PORTS-1:0] ovf_evt;
    logic [NUM_PORTS-1:0] rsp_bad_evt;
    logic [NUM_PORTS-1:0] to_evt;
    logic [NUM_PORTS-1:0] succ_evt;
    logic [NUM_PORTS-1:0] to_port_v;

    logic [7:0]           err_inc_d;
    logic [7:0]           succ_inc_d;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [7:0] inc);
        logic [32:0] s;
        s = {1'b0, a} + {25'd0, inc};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [TS_W-1:0]  mem_q [MAX_OUT];
            logic [PTR_W-1:0] wr_ptr_q;
            logic [PTR_W-1:0] rd_ptr_q;
            logic [CNT_W-1:0] cnt_q;
            logic             head_to_q;
            logic             to_port_q;

            logic             empty;
            logic             full;
            logic             acc;
            logic             rsp;
            logic             pop;
            logic             push;
            logic [TS_W-1:0]  age;

            assign empty = (cnt_q == '0);
            assign full  = (cnt_q == FULL_CNT);
            assign acc   = enable & req_valid[gi] & req_ready[gi];
            assign rsp   = enable & rsp_valid[gi];
            assign pop   = rsp & ~empty;
            // The pop frees a slot in the same cycle, so a full FIFO can still take the push.
            assign push  = acc & (~full | pop);
            assign age   = now_q - mem_q[rd_ptr_q];

            assign ovf_evt[gi]     = acc & full & ~pop;
            assign rsp_bad_evt[gi] = rsp & (empty | rsp_error[gi]);
            assign succ_evt[gi]    = pop & ~rsp_error[gi];
            assign to_evt[gi]      = enable & ~empty & (age >= TIMEOUT_TS) & ~head_to_q;
            assign to_port_v[gi]   = to_port_q;
            assign outstanding[gi*CNT_W +: CNT_W] = cnt_q;

            always_ff @(posedge clk) begin
                if (push) begin
                    mem_q[wr_ptr_q] <= now_q;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr_q  <= '0;
                    rd_ptr_q  <= '0;
                    cnt_q     <= '0;
                    head_to_q <= 1'b0;
                    to_port_q <= 1'b0;
                end else if (clear) begin
                    wr_ptr_q  <= '0;
                    rd_ptr_q  <= '0;
                    cnt_q     <= '0;
                    head_to_q <= 1'b0;
                    to_port_q <= 1'b0;
                end else begin
                    if (push) begin
                        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                    end
                    if (pop) begin
                        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                    end
                    if (push && !pop) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else if (pop && !push) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                    // Timeout fires once per head entry; re-armed when that entry leaves.
                    head_to_q <= pop ? 1'b0 : (head_to_q | to_evt[gi]);
                    if (to_evt[gi]) begin
                        to_port_q <= 1'b1;
                    end
                end
            end

`ifdef TIDC_WDOG_LAT_STATS_EN
            logic [TS_W-1:0] max_lat_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    max_lat_q <= '0;
                end else if (clear) begin
                    max_lat_q <= '0;
                end else if (pop && (age > max_lat_q)) begin
                    max_lat_q <= age;
                end
            end

            assign max_latency[gi*TS_W +: TS_W] = max_lat_q;
`else
            assign max_latency[gi*TS_W +: TS_W] = '0;
`endif
        end
    endgenerate

    always_comb begin
        err_inc_d  = '0;
        succ_inc_d = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            err_inc_d  = err_inc_d + 8'(ovf_evt[p]) + 8'(rsp_bad_evt[p]) + 8'(to_evt[p]);
            succ_inc_d = succ_inc_d + 8'(succ_evt[p]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            now_q         <= '0;
            total_q       <= '0;
            success_q     <= '0;
            error_q       <= '0;
            timeout_det_q <= 1'b0;
        end else if (clear) begin
            now_q         <= '0;
            total_q       <= '0;
            success_q     <= '0;
            error_q       <= '0;
            timeout_det_q <= 1'b0;
        end else if (enable) begin
            now_q     <= now_q + TS_W'(1);
            total_q   <= sat_add(total_q, 8'd1);
            success_q <= sat_add(success_q, succ_inc_d);
            error_q   <= sat_add(error_q, err_inc_d);
            if (|to_evt) begin
                timeout_det_q <= 1'b1;
            end
        end
    end

    assign total_cycles     = total_q;
    assign success_count    = success_q;
    assign error_count      = error_q;
    assign timeout_detected = timeout_det_q;
    assign timeout_port     = to_port_v;

endmodule

// File: doc/tidc_txn_watchdog.md
Name: tidc_txn_watchdog

Overview:
- Parametrised, synthesizable transaction monitor and watchdog for the TIDC bench.
- Supersedes the fixed two-L1 monitor with NUM_PORTS request/response channels.
- Tracks up to MAX_OUT outstanding requests per port in a timestamp FIFO, and measures response latency.
- Flags spurious responses, overflow and timeouts, and keeps saturating success/error/cycle counters.

Parameters:
- NUM_PORTS, 2, number of monitored L1 request/response channels (1..8)
- MAX_OUT, 4, per-port outstanding-request FIFO depth (power of 2, ≥2)
- TS_W, 16, width of free-running timestamp and latency values
- TIMEOUT, 1000, head-of-queue age (cycles) at which a port times out (< 2^TS_W)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  monitoring active; when 0, no pushes/pops/counts (cycle counter also frozen)
- clear  in  1  synchronous clear of counters, FIFOs, sticky flags (priority over all events)
- req_valid  in  NUM_PORTS  per-port request valid
- req_ready  in  NUM_PORTS  per-port request ready (accept = valid&ready)
- rsp_valid  in  NUM_PORTS  per-port response (data_valid) strobe, one per request
- rsp_error  in  NUM_PORTS  per-port response error, qualified by rsp_valid
- total_cycles  out  32  enabled cycles since reset/clear, saturating
- success_count  out  32  responses with rsp_error=0 matched to a request, saturating
- error_count  out  32  sum of all error events, saturating
- timeout_detected  out  1  sticky, any port timed out
- timeout_port  out  NUM_PORTS  sticky per-port timeout flags
- outstanding  out  NUM_PORTS*($clog2(MAX_OUT)+1)  per-port FIFO occupancy, port 0 in LSBs
- max_latency  out  NUM_PORTS*TS_W  per-port maximum observed latency (see Optional Feature)

Behaviour:
- Reset/clear: all outputs 0, all FIFOs empty, timestamp counter 0. Reset is asynchronous to clk; clear takes effect at the next edge.
- now: TS_W-bit free-running counter, +1 per enabled cycle, wraps modulo 2^TS_W.
- Accept on port p (enable & req_valid[p] & req_ready[p]):
  - If the FIFO is not full, push now.
  - If full, raise an overflow error event and drop the push.
- Response on port p (enable & rsp_valid[p]):
  - If the FIFO is non-empty, pop head; latency = (now − head) mod 2^TS_W.
  - If rsp_error=0, success +1; if rsp_error=1, an error event.
  - If the FIFO is empty, raise a spurious error event and do not pop.
- Same-cycle accept and response on one port:
  - The pop uses the pre-push contents, so an empty FIFO still yields spurious plus push.
  - A full FIFO with a pop in the same cycle accepts the push (no overflow); occupancy is unchanged.
- Timeout:
  - Raised when the FIFO is non-empty, enabled, and (now − head) ≥ TIMEOUT.
  - On the first such cycle per head entry: set timeout_port[p] and timeout_detected, one error event.
  - The entry stays queued; no repeated errors until it is popped.
- error_count: adds the popcount of all error events across all ports each cycle (up to 3·NUM_PORTS per cycle), saturating at 32'hFFFF_FFFF.
- success_count and total_cycles: saturate at 32'hFFFF_FFFF.
- Update timing: outputs update the cycle after the event (registered); outstanding reflects post-edge occupancy.
- FIFO pointers: wrap modulo MAX_OUT; occupancy is tracked with a separate counter 0..MAX_OUT.

Optional Feature:
- Macro: TIDC_WDOG_LAT_STATS_EN.
- Defined: max_latency[p] updates to the popped latency when larger; cleared by rst/clear.
- Undefined: max_latency is tied to 0, and the comparator and registers are removed. All other behaviour is identical.

Test Plan:
- NUM_PORTS=2, port0 accept at now=10, rsp_valid at now=17, rsp_error=0 → success_count=1, outstanding0=0, max_latency0=7 (with macro), error_count=0.
- Port1 rsp_valid with empty FIFO and simultaneous accept → error_count=1, success_count=0, outstanding1=1.
- MAX_OUT=4: 5 back-to-back accepts on port0, no responses → outstanding0=4, error_count=1. Then 4 responses → success_count=4.
- TIMEOUT=20: accept on port1, no response for 25 cycles → timeout_port=2'b10 and timeout_detected=1 at age 20, error_count=1 exactly. A later response → success_count=1, flags stay sticky.
- Response with rsp_error=1 on both ports, same cycle, each with one outstanding → error_count +2, success_count unchanged.
- TS_W=4: accept at now=14, response 5 cycles later (now=3 after wrap) → latency 5; assert rst mid-test → all outputs 0 immediately, without waiting for clk.
